// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, timing defaults, command codes and parity helper
package ps2_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_CLK_REL, S_DATA, S_WAIT_IDLE, S_ERROR
   } ps2_state_e;
   localparam int CNT_W = 20;
   localparam int INHIBIT_CYCLES_DEF = 6000;
   localparam int START_TIMEOUT_DEF = 750000;
   localparam int XFER_TIMEOUT_DEF = 100000;
   localparam int IDLE_TIMEOUT_DEF = 100000;
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] CMD_RESET = 8'hFF;
   localparam logic [7:0] RSP_ACK = 8'hFA;
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for a PS/2 pad plus a one-cycle falling-edge strobe
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic fall
);
   logic [2:0] sh_q, sh_d;
   // shift the raw pad through two sync stages and one history stage
   always_comb sh_d = {sh_q[1:0], pad};
   // preset to 1 so an idle (pulled-up) line never produces a spurious edge
   always_ff @(posedge clk or posedge rst)
      if (rst) sh_q <= '1;
      else sh_q <= sh_d;
   assign level = sh_q[1];
   assign fall = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with inhibit, RTS, bit shifting and ACK check
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF,
   parameter int XFER_TIMEOUT = XFER_TIMEOUT_DEF,
   parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] the_command,
   input  logic       send_command,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_dat_drive_low,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_communication_timed_out,
   output logic       error_no_ack
);
   localparam logic [CNT_W-1:0] INH_TC = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_TC = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] XFER_TC = CNT_W'(XFER_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(IDLE_TIMEOUT - 1);

   ps2_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;
   logic [9:0] frame_q, frame_d;
   logic bit_q, bit_d, noack_q, noack_d;
   logic clk_dl_q, clk_dl_d, dat_dl_q, dat_dl_d, busy_q, busy_d;
   logic sent_q, sent_d, to_q, to_d, na_q, na_d;
   logic clk_s, clk_fall, dat_s, dat_fall_unused;

   ps2_line_sync u_clk_sync (.clk(CLOCK_50), .rst(reset), .pad(ps2_clk_in), .level(clk_s), .fall(clk_fall));
   ps2_line_sync u_dat_sync (.clk(CLOCK_50), .rst(reset), .pad(ps2_dat_in), .level(dat_s), .fall(dat_fall_unused));

   // handshake sequencing; frame is shifted out LSB first, one bit per device falling edge
   always_comb begin
      state_d = state_q;
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      frame_d = frame_q;
      bit_d = bit_q;
      noack_d = noack_q;
      sent_d = 1'b0;
      to_d = 1'b0;
      na_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (send_command) begin
               frame_d = {1'b1, odd_parity(the_command), the_command};
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: if (cnt_q == INH_TC) state_d = S_RTS;
         S_RTS: begin
            cnt_d = '0;
            state_d = S_CLK_REL;
         end
         S_CLK_REL:
            if (clk_fall) begin
               bit_d = frame_q[0];
               frame_d = {1'b1, frame_q[9:1]};
               idx_d = 4'd1;
               cnt_d = '0;
               state_d = S_DATA;
            end else if (cnt_q == START_TC) begin
               noack_d = 1'b0;
               state_d = S_ERROR;
            end
         S_DATA:
            if (clk_fall) begin
               if (idx_q == 4'd10) begin
                  cnt_d = '0;
                  noack_d = dat_s;
                  state_d = dat_s ? S_ERROR : S_WAIT_IDLE;
               end else begin
                  bit_d = frame_q[0];
                  frame_d = {1'b1, frame_q[9:1]};
                  idx_d = idx_q + 4'd1;
               end
            end else if (cnt_q == XFER_TC) begin
               noack_d = 1'b0;
               state_d = S_ERROR;
            end
         S_WAIT_IDLE:
            if (clk_s && dat_s) begin
               sent_d = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == IDLE_TC) begin
               noack_d = 1'b0;
               state_d = S_ERROR;
            end
         S_ERROR: begin
            to_d = ~noack_q;
            na_d = noack_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      clk_dl_d = state_d inside {S_INHIBIT, S_RTS};
      dat_dl_d = (state_d inside {S_RTS, S_CLK_REL}) || (state_d == S_DATA && !bit_d);
      busy_d = state_d != S_IDLE;
   end

   // state and registered outputs; reset releases both lines at once
   always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         frame_q <= '0;
         bit_q <= 1'b1;
         noack_q <= 1'b0;
         clk_dl_q <= 1'b0;
         dat_dl_q <= 1'b0;
         busy_q <= 1'b0;
         sent_q <= 1'b0;
         to_q <= 1'b0;
         na_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         frame_q <= frame_d;
         bit_q <= bit_d;
         noack_q <= noack_d;
         clk_dl_q <= clk_dl_d;
         dat_dl_q <= dat_dl_d;
         busy_q <= busy_d;
         sent_q <= sent_d;
         to_q <= to_d;
         na_q <= na_d;
      end

   assign ps2_clk_drive_low = clk_dl_q;
   assign ps2_dat_drive_low = dat_dl_q;
   assign busy = busy_q;
   assign command_was_sent = sent_q;
   assign error_communication_timed_out = to_q;
   assign error_no_ack = na_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host-transmit bench with an open-drain device model and frame reference
module tb_ps2_host_tx;
   import ps2_pkg::*;
   localparam int INH = 200;
   localparam int START = 3000;
   localparam int XFER = 1500;
   localparam int IDLE = 500;
   localparam int HALF = 25;

   logic clk = 1'b0, reset = 1'b1, send_command = 1'b0;
   logic [7:0] the_command = '0;
   logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
   logic ps2_clk, ps2_dat, clk_dl, dat_dl, busy, sent, to, na;
   int n_vec = 0, n_err = 0;
   int cyc = 0, rel_cyc = 0, to_cyc = 0, fall0_cyc = 0;
   int n_sent = 0, n_to = 0, n_na = 0, busy_bad = 0, inh_run = 0, inh_last = 0;
   logic busy_exp = 1'b0, clk_dl_prev = 1'b0;

   assign ps2_clk = ~(clk_dl | dev_clk_low);
   assign ps2_dat = ~(dat_dl | dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .XFER_TIMEOUT(XFER), .IDLE_TIMEOUT(IDLE)) dut (
      .CLOCK_50(clk), .reset(reset), .the_command(the_command), .send_command(send_command),
      .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat), .ps2_clk_drive_low(clk_dl), .ps2_dat_drive_low(dat_dl),
      .busy(busy), .command_was_sent(sent), .error_communication_timed_out(to), .error_no_ack(na)
   );

   always #10 clk = ~clk;

   // passive monitor: pulse counters, inhibit length, busy coverage of each accepted request
   always @(negedge clk) begin
      cyc++;
      if (reset) busy_exp = 1'b0;
      else begin
         if (clk_dl_prev && !clk_dl) rel_cyc = cyc;
         if (clk_dl && !dat_dl) inh_run++;
         else if (inh_run != 0) begin
            inh_last = inh_run;
            inh_run = 0;
         end
         if (sent) n_sent++;
         if (na) n_na++;
         if (to) begin
            n_to++;
            to_cyc = cyc;
         end
         if (sent || to || na) begin
            if (busy) busy_bad++;
            busy_exp = 1'b0;
         end else if (busy_exp && !busy) busy_bad++;
         if (send_command && !busy) busy_exp = 1'b1;
      end
      clk_dl_prev = clk_dl;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference frame as the device should see it: start, 8 data LSB first, odd parity, stop
   function automatic logic [10:0] model_frame(input logic [7:0] c);
      logic [10:0] f;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = c[i];
         ones += int'(c[i]);
      end
      f[9] = (ones % 2) == 0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // device: waits for request-to-send, then clocks `edges` falls, sampling DAT before each fall
   task automatic device(input int edges, input bit ack, output logic [10:0] smp);
      int t = 0;
      smp = '0;
      while (!(!clk_dl && dat_dl) && t < INH + 100) begin
         tick(1);
         t++;
      end
      if (t >= INH + 100) chk("rts_seen", 0, 1);
      for (int i = 0; i < edges; i++) begin
         tick(HALF);
         if (i < 11) smp[i] = ps2_dat;
         if (i == 0) fall0_cyc = cyc;
         if (i == 10 && ack) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         tick(HALF);
         dev_clk_low = 1'b0;
      end
      tick(HALF);
      dev_dat_low = 1'b0;
   endtask

   task automatic run_tx(input logic [7:0] cmd, input int edges, input bit ack);
      logic [10:0] smp, exp_f, mask;
      int bs = n_sent, bt = n_to, bn = n_na, t = 0;
      exp_f = model_frame(cmd);
      mask = edges >= 11 ? 11'h7FF : 11'((1 << edges) - 1);
      the_command = cmd;
      send_command = 1'b1;
      tick(1);
      send_command = 1'b0;
      tick(1);
      chk("accept_busy", busy, 1);
      tick(5);
      the_command = ~cmd;
      send_command = 1'b1;
      tick(1);
      send_command = 1'b0;
      device(edges, ack, smp);
      while (n_sent == bs && n_to == bt && n_na == bn && t < START + XFER + IDLE) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (t >= START + XFER + IDLE) chk("outcome_wait", 0, 1);
      chk("frame", smp & mask, exp_f & mask);
      chk("inhibit_len", inh_last, INH);
      chk("sent", n_sent - bs, (edges >= 11 && ack) ? 1 : 0);
      chk("no_ack", n_na - bn, (edges >= 11 && !ack) ? 1 : 0);
      chk("timeout", n_to - bt, edges < 11 ? 1 : 0);
      chk("busy_cover", busy_bad, 0);
      chk("lines_free", {clk_dl, dat_dl, busy}, 0);
   endtask

   initial begin
      logic [10:0] smp;
      int b;
      tick(3);
      chk("rst_out", {clk_dl, dat_dl, busy, sent, to, na}, 0);
      reset = 1'b0;
      tick(3);
      run_tx(CMD_SET_LEDS, 11, 1);
      run_tx(CMD_ENABLE, 11, 1);
      run_tx(8'h3C, 0, 0);
      chk("start_to_time", 32'(to_cyc - rel_cyc), START + 1);
      run_tx(8'hA5, 11, 0);
      run_tx(8'h81, 5, 0);
      b = to_cyc - fall0_cyc;
      chk("xfer_to_window", (b >= XFER && b <= XFER + 8) ? 1 : 0, 1);
      run_tx(CMD_ENABLE, 11, 1);
      b = n_sent + n_to + n_na;
      the_command = 8'h52;
      send_command = 1'b1;
      tick(1);
      send_command = 1'b0;
      device(4, 0, smp);
      chk("pre_rst_dat", dat_dl, 1);
      #1 reset = 1'b1;
      #1 chk("rst_async", {clk_dl, dat_dl, busy}, 0);
      tick(3);
      reset = 1'b0;
      tick(START);
      chk("rst_no_pulse", n_sent + n_to + n_na, b);
      run_tx(CMD_RESET, 11, 1);
      for (int i = 0; i < 6; i++) run_tx(8'($urandom), 11, $urandom_range(0, 3) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
